// File: rtl/fastserial_stream_bridge.sv
// Buffered bridge between the FTDI fast-serial byte engines and Avalon-ST byte streams.
// RX/TX FIFOs, TX handshake FSM keyed to the serializer busy flag, and drop/timeout statistics.
module fastserial_stream_bridge #(
  parameter int DATA_W      = 8,
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [DATA_W-1:0]           i_rx_data,
  input  logic                        i_rx_ready,
  output logic                        o_rx_valid,
  output logic [DATA_W-1:0]           o_rx_data,
  input  logic                        i_rx_sink_ready,
  input  logic                        i_tx_valid,
  input  logic [DATA_W-1:0]           i_tx_data,
  output logic                        o_tx_src_ready,
  output logic [DATA_W-1:0]           o_tx_data,
  output logic                        o_tx_write,
  input  logic                        i_tx_busy,
  input  logic                        i_clear_stats,
  output logic [$clog2(RX_DEPTH):0]   o_rx_level,
  output logic [$clog2(TX_DEPTH):0]   o_tx_level,
  output logic                        o_rx_overflow,
  output logic [CNT_W-1:0]            o_rx_drop_cnt,
  output logic [CNT_W-1:0]            o_tx_timeout_cnt
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_LW = RX_AW + 1;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_LW = TX_AW + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t state;

  // RX FIFO (first-word-fall-through)
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wr_ptr;
  logic [RX_AW-1:0]  rx_rd_ptr;
  logic              rx_full;
  logic              rx_pop;
  logic              rx_push;
  logic              rx_drop;

  assign rx_full    = (o_rx_level == RX_LW'(RX_DEPTH));
  assign o_rx_valid = (o_rx_level != '0);
  assign o_rx_data  = rx_mem[rx_rd_ptr];
  assign rx_pop     = o_rx_valid && i_rx_sink_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign rx_push    = i_rx_ready && (!rx_full || rx_pop);
  assign rx_drop    = i_rx_ready && rx_full && !rx_pop;

  always_ff @(posedge i_clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= i_rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      o_rx_level <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      end
      if (rx_push && !rx_pop) begin
        o_rx_level <= o_rx_level + RX_LW'(1);
      end else if (!rx_push && rx_pop) begin
        o_rx_level <= o_rx_level - RX_LW'(1);
      end
    end
  end

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_ptr;
  logic [TX_AW-1:0]  tx_rd_ptr;
  logic              tx_push;
  logic              tx_pop;
  logic [TX_LW-1:0]  tx_level_nxt;

  assign tx_push = i_tx_valid && o_tx_src_ready;
  assign tx_pop  = (state == IDLE) && (o_tx_level != '0) && !i_tx_busy;

  always_comb begin
    tx_level_nxt = o_tx_level;
    if (tx_push && !tx_pop) begin
      tx_level_nxt = o_tx_level + TX_LW'(1);
    end else if (!tx_push && tx_pop) begin
      tx_level_nxt = o_tx_level - TX_LW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= i_tx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      o_tx_level     <= '0;
      o_tx_src_ready <= 1'b1;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      end
      o_tx_level     <= tx_level_nxt;
      o_tx_src_ready <= (tx_level_nxt != TX_LW'(TX_DEPTH));
    end
  end

  // TX handshake FSM
  logic [TMR_W-1:0] ack_timer;
  logic             ack_timeout;

  assign ack_timeout = (state == WAIT_ACK) && !i_tx_busy && (ack_timer == TMR_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      o_tx_data  <= '0;
      o_tx_write <= 1'b0;
      ack_timer  <= '0;
    end else begin
      o_tx_write <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_pop) begin
            o_tx_data  <= tx_mem[tx_rd_ptr];
            o_tx_write <= 1'b1;
            state      <= STROBE;
          end
        end
        STROBE: begin
          ack_timer <= '0;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_tx_busy) begin
            state <= WAIT_DONE;
          end else if (ack_timeout) begin
            state <= IDLE;
          end else begin
            ack_timer <= ack_timer + TMR_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics; clear wins over a same-cycle event
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear_stats) begin
      o_rx_overflow    <= 1'b0;
      o_rx_drop_cnt    <= '0;
      o_tx_timeout_cnt <= '0;
    end else begin
      if (rx_drop) begin
        o_rx_overflow <= 1'b1;
        if (o_rx_drop_cnt != '1) begin
          o_rx_drop_cnt <= o_rx_drop_cnt + CNT_W'(1);
        end
      end
      if (ack_timeout && (o_tx_timeout_cnt != '1)) begin
        o_tx_timeout_cnt <= o_tx_timeout_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fastserial_stream_bridge.sv
// Scoreboard bench for fastserial_stream_bridge: queued expected bytes are compared
// as the DUT presents them on the RX stream and on each TX write strobe.
module tb_fastserial_stream_bridge;

  localparam int DW  = 8;
  localparam int RXD = 16;
  localparam int TXD = 16;
  localparam int ACK = 64;
  localparam int CW  = 16;

  logic                     clk = 1'b0;
  logic                     i_reset;
  logic [DW-1:0]            i_rx_data;
  logic                     i_rx_ready;
  logic                     o_rx_valid;
  logic [DW-1:0]            o_rx_data;
  logic                     i_rx_sink_ready;
  logic                     i_tx_valid;
  logic [DW-1:0]            i_tx_data;
  logic                     o_tx_src_ready;
  logic [DW-1:0]            o_tx_data;
  logic                     o_tx_write;
  logic                     i_tx_busy;
  logic                     i_clear_stats;
  logic [$clog2(RXD):0]     o_rx_level;
  logic [$clog2(TXD):0]     o_tx_level;
  logic                     o_rx_overflow;
  logic [CW-1:0]            o_rx_drop_cnt;
  logic [CW-1:0]            o_tx_timeout_cnt;

  always #5 clk = ~clk;

  fastserial_stream_bridge #(
    .DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .ACK_TIMEOUT(ACK), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_ready(i_rx_ready),
    .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .i_rx_sink_ready(i_rx_sink_ready),
    .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data), .o_tx_src_ready(o_tx_src_ready),
    .o_tx_data(o_tx_data), .o_tx_write(o_tx_write), .i_tx_busy(i_tx_busy),
    .i_clear_stats(i_clear_stats),
    .o_rx_level(o_rx_level), .o_tx_level(o_tx_level),
    .o_rx_overflow(o_rx_overflow), .o_rx_drop_cnt(o_rx_drop_cnt),
    .o_tx_timeout_cnt(o_tx_timeout_cnt)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] tx_q[$];
  int unsigned   strobe_cyc[$];
  int            rx_popped = 0;
  logic          prev_write = 1'b0;

  // Busy model: rises 3 cycles after a strobe, stays high 10 cycles
  int          busy_mode = 0;
  logic        busy_hold = 1'b0;
  logic        model_busy = 1'b0;
  int unsigned fall_cyc = 0;
  assign i_tx_busy = busy_hold | model_busy;

  initial begin
    forever begin
      @(negedge clk);
      if (busy_mode == 1 && o_tx_write) begin
        repeat (3) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 model_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!i_reset && o_rx_valid && i_rx_sink_ready) begin
      if (rx_q.size() == 0) check("rx_unexpected_byte", 32'(o_rx_data), 32'hFFFF_FFFF);
      else check("rx_data", 32'(o_rx_data), 32'(rx_q.pop_front()));
      rx_popped++;
    end
  end

  always @(negedge clk) begin
    if (o_tx_write) begin
      check("tx_single_cycle_strobe", 32'(prev_write), 32'd0);
      if (tx_q.size() == 0) check("tx_unexpected_strobe", 32'(o_tx_data), 32'hFFFF_FFFF);
      else check("tx_data", 32'(o_tx_data), 32'(tx_q.pop_front()));
      strobe_cyc.push_back(cyc);
    end
    prev_write = o_tx_write;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_rx(input string tag);
    int guard;
    guard = 0;
    i_rx_sink_ready = 1'b1;
    while (o_rx_level != '0 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check({tag, "_drain_timeout"}, 32'(o_rx_level), 32'd0);
    i_rx_sink_ready = 1'b0;
    check({tag, "_queue_empty"}, 32'(rx_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, guard, n;
    int unsigned t0, gap;
    i_reset = 1'b1; i_rx_data = '0; i_rx_ready = 1'b0; i_rx_sink_ready = 1'b0;
    i_tx_valid = 1'b0; i_tx_data = '0; i_clear_stats = 1'b0;
    tick(); tick();
    check("reset_rx_level", 32'(o_rx_level), 32'd0);
    check("reset_tx_level", 32'(o_tx_level), 32'd0);
    check("reset_rx_valid", 32'(o_rx_valid), 32'd0);
    check("reset_tx_write", 32'(o_tx_write), 32'd0);
    check("reset_tx_data", 32'(o_tx_data), 32'd0);
    check("reset_tx_src_ready", 32'(o_tx_src_ready), 32'd1);
    check("reset_overflow", 32'(o_rx_overflow), 32'd0);
    check("reset_drop_cnt", 32'(o_rx_drop_cnt), 32'd0);
    check("reset_timeout_cnt", 32'(o_tx_timeout_cnt), 32'd0);
    i_reset = 1'b0;
    tick();

    // RX: five bytes with sink ready, each visible one cycle after its strobe
    i_rx_sink_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_rx_ready = 1'b1;
      i_rx_data  = 8'(8'h11 + i);
      rx_q.push_back(8'(8'h11 + i));
      tick();
      check("rx_latency_data", 32'(o_rx_data), 32'(8'h11 + i));
    end
    i_rx_ready = 1'b0;
    tick(); tick();
    check("rx_level_after_stream", 32'(o_rx_level), 32'd0);
    check("rx_stream_queue_empty", 32'(rx_q.size()), 32'd0);

    // RX overflow: 20 strobes into a 16-deep FIFO with no sink
    i_rx_sink_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_rx_ready = 1'b1;
      i_rx_data  = 8'(8'h20 + i);
      if (i < RXD) rx_q.push_back(8'(8'h20 + i));
      tick();
    end
    i_rx_ready = 1'b0;
    tick();
    check("ovf_rx_level", 32'(o_rx_level), 32'(RXD));
    check("ovf_drop_cnt", 32'(o_rx_drop_cnt), 32'd4);
    check("ovf_overflow_flag", 32'(o_rx_overflow), 32'd1);
    p0 = rx_popped;
    drain_rx("ovf");
    check("ovf_drained_count", 32'(rx_popped - p0), 32'(RXD));

    // Full FIFO with a strobe coincident with a pop
    for (int i = 0; i < RXD; i++) begin
      i_rx_ready = 1'b1;
      i_rx_data  = 8'(8'h40 + i);
      rx_q.push_back(8'(8'h40 + i));
      tick();
    end
    i_rx_ready = 1'b1; i_rx_data = 8'h5A; i_rx_sink_ready = 1'b1;
    rx_q.push_back(8'h5A);
    tick();
    i_rx_ready = 1'b0; i_rx_sink_ready = 1'b0;
    check("coincident_rx_level", 32'(o_rx_level), 32'(RXD));
    check("coincident_drop_cnt", 32'(o_rx_drop_cnt), 32'd4);
    // Clear wins over a drop in the same cycle
    i_rx_ready = 1'b1; i_rx_data = 8'hEE; i_clear_stats = 1'b1;
    tick();
    i_rx_ready = 1'b0; i_clear_stats = 1'b0;
    check("clear_prio_drop_cnt", 32'(o_rx_drop_cnt), 32'd0);
    check("clear_prio_overflow", 32'(o_rx_overflow), 32'd0);
    check("clear_keeps_fifo", 32'(o_rx_level), 32'(RXD));
    drain_rx("coincident");

    // TX with handshaking busy model
    busy_mode = 1;
    strobe_cyc.delete();
    i_tx_valid = 1'b1; i_tx_data = 8'hA5; tx_q.push_back(8'hA5);
    t0 = cyc;
    tick();
    i_tx_data = 8'hB6; tx_q.push_back(8'hB6);
    tick();
    i_tx_valid = 1'b0;
    guard = 0;
    while (strobe_cyc.size() < 2 && guard < 200) begin tick(); guard++; end
    check("tx_busy_two_strobes", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() >= 2) begin
      check("tx_latency", strobe_cyc[0] - t0, 32'd2);
      gap = strobe_cyc[1] - fall_cyc;
      check("tx_gap_after_busy_fall", 32'(gap >= 1 && gap <= 2), 32'd1);
    end
    repeat (20) tick();
    check("tx_no_extra_strobes", 32'(strobe_cyc.size()), 32'd2);
    check("tx_busy_no_timeout", 32'(o_tx_timeout_cnt), 32'd0);
    check("tx_level_empty", 32'(o_tx_level), 32'd0);
    busy_mode = 0;

    // Busy tied low: every strobe times out after ACK cycles
    strobe_cyc.delete();
    i_tx_valid = 1'b1; i_tx_data = 8'hC3; tx_q.push_back(8'hC3);
    tick();
    i_tx_data = 8'h3C; tx_q.push_back(8'h3C);
    tick();
    i_tx_valid = 1'b0;
    guard = 0;
    while (strobe_cyc.size() < 2 && guard < 400) begin tick(); guard++; end
    check("timeout_two_strobes", 32'(strobe_cyc.size()), 32'd2);
    check("timeout_cnt_after_first", 32'(o_tx_timeout_cnt), 32'd1);
    if (strobe_cyc.size() >= 2) begin
      check("timeout_strobe_spacing", strobe_cyc[1] - strobe_cyc[0], 32'(ACK + 2));
      guard = 0;
      while (o_tx_timeout_cnt != 16'd2 && guard < 200) begin tick(); guard++; end
      check("timeout_cnt_second", 32'(o_tx_timeout_cnt), 32'd2);
      check("timeout_second_timing", cyc - strobe_cyc[1], 32'(ACK + 1));
    end
    i_clear_stats = 1'b1;
    tick();
    i_clear_stats = 1'b0;
    check("timeout_cnt_cleared", 32'(o_tx_timeout_cnt), 32'd0);

    // Fill the TX FIFO while busy, then reset while in STROBE
    busy_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_tx_valid = 1'b1;
      i_tx_data  = 8'(8'h80 + i);
      if (o_tx_src_ready) tx_q.push_back(8'(8'h80 + i));
      tick();
    end
    i_tx_valid = 1'b0;
    check("tx_full_level", 32'(o_tx_level), 32'(TXD));
    check("tx_full_src_ready", 32'(o_tx_src_ready), 32'd0);
    check("tx_full_queue", 32'(tx_q.size()), 32'(TXD));
    busy_hold = 1'b0;
    guard = 0;
    while (!o_tx_write && guard < 20) begin tick(); guard++; end
    check("reset_test_strobe_seen", 32'(o_tx_write), 32'd1);
    check("reset_test_level_in_strobe", 32'(o_tx_level), 32'(TXD - 1));
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("midreset_tx_write", 32'(o_tx_write), 32'd0);
    check("midreset_tx_level", 32'(o_tx_level), 32'd0);
    check("midreset_src_ready", 32'(o_tx_src_ready), 32'd1);
    tx_q.delete();
    n = strobe_cyc.size();
    repeat (100) tick();
    check("midreset_no_strobes", 32'(strobe_cyc.size()), 32'(n));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
